display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
- Time-multiplexes NUM_DIGITS common-anode 7-segment digits through one shared BCD-to-7-segment decoder.
- The decoder is an external combinational block fed by dec_nibble; its segment output drives all digits in parallel.
- Holds a double-buffered digit store: a writer fills a shadow bank, and a commit request copies it to the active bank only at a frame boundary, so the display never tears.
- Sequences each digit slot as a blanking interval followed by a show interval to suppress ghosting.

Parameters:
- NUM_DIGITS, 4, digits scanned (2..8).
- SLOT_CYCLES, 50000, clock cycles per digit slot (blank plus show).
- BLANK_CYCLES, 16, cycles per slot with all anodes off; must be at least 1 and less than SLOT_CYCLES.

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  synchronous reset, active-low; sampled only on the rising edge of Clock.
- enable  in  1  1 = scanning; 0 = display dark.
- wr_valid  in  1  shadow write strobe.
- wr_digit  in  3  shadow digit index; values at or above NUM_DIGITS are ignored.
- wr_data  in  4  nibble to store.
- commit  in  1  request shadow-to-active copy.
- commit_busy  out  1  commit pending, not yet applied.
- commit_done  out  1  one-cycle pulse when the copy happens.
- dec_nibble  out  4  value to the shared decoder.
- digit_an  out  NUM_DIGITS  anode selects, active-low, one-hot-low while showing.
- frame_tick  out  1  one-cycle pulse at the end of the last digit's slot.

Behaviour:
- Reset (Resetn=0 at an edge):
  - state=OFF, idx=0, slot counter=0.
  - Shadow and active banks cleared to 4'h0.
  - digit_an all 1, dec_nibble=0, commit_busy=0, commit_done=0, frame_tick=0.
  - Reset mid-frame or mid-commit abandons everything; no commit_done is issued.
- FSM states: OFF, BLANK, SHOW.
  - OFF -> BLANK when enable=1. Enters with idx=0 and counter=0.
  - BLANK -> SHOW when counter reaches BLANK_CYCLES-1.
  - SHOW -> BLANK when counter reaches SLOT_CYCLES-1. idx advances, wrapping NUM_DIGITS-1 -> 0; counter resets to 0.
  - Any state -> OFF on the edge after enable=0. idx=0, digit_an all 1.
- Outputs by state (all registered):
  - BLANK: digit_an all 1; dec_nibble=active[idx], so the decoder settles before the anode turns on.
  - SHOW: digit_an[idx]=0, all other bits 1; dec_nibble=active[idx].
  - OFF: digit_an all 1; dec_nibble holds its last value.
- Slot timing: each digit slot is exactly SLOT_CYCLES cycles, so a frame is NUM_DIGITS*SLOT_CYCLES cycles.
- frame_tick: asserted during the last cycle of SHOW for idx=NUM_DIGITS-1.
- Shadow writes:
  - A write with wr_valid=1 and wr_digit<NUM_DIGITS updates shadow[wr_digit] on that edge, in any state.
  - Writes are always accepted; there is no back-pressure.
- Commit:
  - commit=1 sets commit_busy on the next edge; further commit pulses while busy are absorbed.
  - The copy occurs on the frame_tick edge, or on the next edge if the state is OFF.
  - The copy takes all shadow entries at once, including a write landing in that same cycle.
  - commit_done pulses for one cycle in the cycle after the copy, and commit_busy clears simultaneously.
  - commit and frame_tick in the same cycle: the copy happens at that frame_tick.
- enable dropping while commit_busy=1: the copy happens on the next edge in OFF.
- Counter width: clog2(SLOT_CYCLES). Index width: clog2(NUM_DIGITS), minimum 1.

Decomposition:
- Shared package: state enum (OFF/BLANK/SHOW), the nibble type (4 bits), and the anode-off constant (all ones).
- Natural sub-module: digit_bank. It holds the shadow and active register arrays, the write port, and the commit copy, and exposes active[idx].
- display_scan_ctrl keeps the FSM, the counters, and commit sequencing.

Test Plan:
All scenarios use NUM_DIGITS=4, SLOT_CYCLES=8, BLANK_CYCLES=2.
- Reset then enable=1: digit_an=4'b1111 for 2 cycles, then 4'b1110 for 6 cycles, then 1111/1101 and onward. frame_tick pulses every 32 cycles, and dec_nibble=0 throughout.
- Write shadow digits 0..3 with 1,2,3,4 and no commit: dec_nibble stays 0. Then pulse commit mid-frame: commit_busy=1 until frame_tick, commit_done pulses once, and the next frame shows 1,2,3,4 in slot order.
- commit pulsed 3 times in one frame: exactly one commit_done. A write to digit 2 (value 9) on the frame_tick cycle appears in the next frame.
- wr_digit=5 with wr_valid=1: no bank change; display values unchanged after a commit.
- enable=0 during SHOW of digit 2 with commit_busy=1: next edge digit_an=1111 and idx=0; copy on the following edge, commit_done pulses. Re-enable restarts at BLANK of digit 0.
- Resetn=0 mid-commit during SHOW: all outputs return to reset values on that edge, both banks read 0, and no commit_done appears.

Source files
------------

// File: rtl/display_scan_ctrl_pkg.sv
// Shared types for the display scan controller.
//   scan_state_t : scan FSM states (off, blanking interval, show interval)
//   nibble_t     : one BCD digit as stored in the banks and fed to the decoder
//   ANODE_OFF    : all-anodes-off pattern; callers slice it to NUM_DIGITS bits
package display_scan_ctrl_pkg;
  typedef enum logic [1:0] {ST_OFF, ST_BLANK, ST_SHOW} scan_state_t;
  typedef logic [3:0] nibble_t;
  localparam logic [7:0] ANODE_OFF = 8'hFF;
endpackage

// File: rtl/display_scan_ctrl_digit_bank.sv
// Double-buffered digit store.
//   Clock, Resetn : clock and synchronous active-low reset
//   wr_valid, wr_digit, wr_data : shadow write port (out-of-range index ignored)
//   copy          : load every active entry from the shadow bank this edge
//   rd_idx/rd_data: combinational read of the active bank
module display_scan_ctrl_digit_bank
  import display_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int IDX_W      = 2
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             wr_valid,
  input  logic [2:0]       wr_digit,
  input  nibble_t          wr_data,
  input  logic             copy,
  input  logic [IDX_W-1:0] rd_idx,
  output nibble_t          rd_data
);
  nibble_t shadow     [NUM_DIGITS];
  nibble_t active     [NUM_DIGITS];
  nibble_t shadow_nxt [NUM_DIGITS];

  // Shadow contents after this cycle's write; the copy takes this view so a
  // write landing on the copy edge is carried into the active bank.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++)
      shadow_nxt[i] = (wr_valid && wr_digit == 3'(i)) ? wr_data : shadow[i];
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= shadow_nxt[i];
        if (copy) active[i] <= shadow_nxt[i];
      end
    end
  end

  assign rd_data = active[rd_idx];
endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller.
//   Clock, Resetn : clock and synchronous active-low reset
//   enable        : 1 = scan, 0 = dark
//   wr_valid/wr_digit/wr_data : shadow bank write port
//   commit        : request shadow->active copy at the next frame boundary
//   commit_busy   : copy pending;  commit_done : one-cycle pulse after the copy
//   dec_nibble    : digit value to the shared decoder
//   digit_an      : active-low anode selects
//   frame_tick    : pulse during the final cycle of the last digit's slot
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  enable,
  input  logic                  wr_valid,
  input  logic [2:0]            wr_digit,
  input  logic [3:0]            wr_data,
  input  logic                  commit,
  output logic                  commit_busy,
  output logic                  commit_done,
  output logic [3:0]            dec_nibble,
  output logic [NUM_DIGITS-1:0] digit_an,
  output logic                  frame_tick
);
  localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(SLOT_CYCLES);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_END  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TICK_PRE  = CNT_W'(SLOT_CYCLES - 2);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = ANODE_OFF[NUM_DIGITS-1:0];

  scan_state_t      state;
  logic [IDX_W-1:0] idx, nxt_idx;
  logic [CNT_W-1:0] cnt;
  nibble_t          rd_data;
  logic             do_copy;

  // Index that will be current after this edge; the bank is read with it so
  // dec_nibble already matches the digit of the slot being entered.
  always_comb begin
    nxt_idx = idx;
    if (state == ST_OFF)
      nxt_idx = '0;
    else if (state == ST_SHOW && cnt == SLOT_END)
      nxt_idx = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
  end

  // Copy at the frame boundary, or straight away once the scan is off.
  assign do_copy = (commit_busy && (frame_tick || state == ST_OFF)) ||
                   (commit && frame_tick);

  display_scan_ctrl_digit_bank #(.NUM_DIGITS(NUM_DIGITS), .IDX_W(IDX_W)) u_bank (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .wr_valid (wr_valid),
    .wr_digit (wr_digit),
    .wr_data  (wr_data),
    .copy     (do_copy),
    .rd_idx   (nxt_idx),
    .rd_data  (rd_data)
  );

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state      <= ST_OFF;
      idx        <= '0;
      cnt        <= '0;
      digit_an   <= AN_OFF;
      dec_nibble <= '0;
      frame_tick <= 1'b0;
    end else if (!enable) begin
      state      <= ST_OFF;
      idx        <= '0;
      cnt        <= '0;
      digit_an   <= AN_OFF;
      frame_tick <= 1'b0;
    end else begin
      dec_nibble <= rd_data;
      // The counter runs through blank and show, so SLOT_CYCLES-2 is always
      // the cycle before the slot's last one, whichever phase it falls in.
      frame_tick <= (state != ST_OFF) && (cnt == TICK_PRE) && (idx == LAST_IDX);
      case (state)
        ST_OFF: begin
          state    <= ST_BLANK;
          idx      <= '0;
          cnt      <= '0;
          digit_an <= AN_OFF;
        end
        ST_BLANK: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == BLANK_END) begin
            state    <= ST_SHOW;
            digit_an <= ~(NUM_DIGITS'(1) << idx);
          end
        end
        ST_SHOW: begin
          if (cnt == SLOT_END) begin
            state    <= ST_BLANK;
            cnt      <= '0;
            idx      <= nxt_idx;
            digit_an <= AN_OFF;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_OFF;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      commit_busy <= 1'b0;
      commit_done <= 1'b0;
    end else begin
      commit_done <= do_copy;
      if (do_copy)     commit_busy <= 1'b0;
      else if (commit) commit_busy <= 1'b1;
    end
  end
endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;
  localparam int N = 4;
  localparam int S = 8;
  localparam int B = 2;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       enable = 1'b0;
  logic       wr_valid = 1'b0;
  logic [2:0] wr_digit = '0;
  logic [3:0] wr_data = '0;
  logic       commit = 1'b0;
  logic       commit_busy, commit_done, frame_tick;
  logic [3:0] dec_nibble;
  logic [N-1:0] digit_an;

  display_scan_ctrl #(.NUM_DIGITS(N), .SLOT_CYCLES(S), .BLANK_CYCLES(B)) dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .enable      (enable),
    .wr_valid    (wr_valid),
    .wr_digit    (wr_digit),
    .wr_data     (wr_data),
    .commit      (commit),
    .commit_busy (commit_busy),
    .commit_done (commit_done),
    .dec_nibble  (dec_nibble),
    .digit_an    (digit_an),
    .frame_tick  (frame_tick)
  );

  always #5 Clock = ~Clock;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;

  // Reference model: scan position is just elapsed cycles since scanning began.
  bit         m_on = 0;
  int         m_t = 0;
  bit         m_busy = 0;
  bit         m_done = 0;
  logic [3:0] m_sh [N];
  logic [3:0] m_act[N];

  function automatic int m_slot();  return (m_t / S) % N; endfunction
  function automatic int m_phase(); return m_t % S;       endfunction
  function automatic bit m_tick();
    return m_on && m_slot() == N - 1 && m_phase() == S - 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    bit cp;
    logic [3:0] nsh[N];
    logic [3:0] exp_an;
    @(posedge Clock);
    if (!Resetn) begin
      m_on = 0; m_t = 0; m_busy = 0; m_done = 0;
      for (int i = 0; i < N; i++) begin m_sh[i] = '0; m_act[i] = '0; end
    end else begin
      cp = (m_busy && (m_tick() || !m_on)) || (commit && m_tick());
      for (int i = 0; i < N; i++) nsh[i] = m_sh[i];
      if (wr_valid && wr_digit < N) nsh[wr_digit] = wr_data;
      for (int i = 0; i < N; i++) begin
        m_sh[i] = nsh[i];
        if (cp) m_act[i] = nsh[i];
      end
      m_done = cp;
      m_busy = cp ? 1'b0 : (m_busy || commit);
      if (!enable)    begin m_on = 0; m_t = 0; end
      else if (!m_on) begin m_on = 1; m_t = 0; end
      else            m_t = (m_t + 1) % (N * S);
    end
    #1;
    wr_valid = 1'b0;
    commit   = 1'b0;
    exp_an = (m_on && m_phase() >= B) ? ~(4'b0001 << m_slot()) : 4'hF;
    chk("digit_an", digit_an, exp_an);
    chk("frame_tick", frame_tick, m_tick());
    chk("commit_busy", commit_busy, m_busy);
    chk("commit_done", commit_done, m_done);
    if (m_on && m_phase() >= B) chk("dec_nibble_show", dec_nibble, m_act[m_slot()]);
    if (!Resetn) chk("dec_nibble_rst", dec_nibble, 0);
    if (commit_done) done_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_show(input int s);
    int k = 0;
    while (!(m_on && m_slot() == s && m_phase() >= B) && k < 200) begin step(); k++; end
    chk("wait_show_bound", k < 200, 1);
  endtask

  task automatic wait_tick();
    int k = 0;
    while (!m_tick() && k < 200) begin step(); k++; end
    chk("wait_tick_bound", k < 200, 1);
  endtask

  task automatic wr(input int d, input int v);
    wr_valid = 1'b1; wr_digit = 3'(d); wr_data = 4'(v);
    step();
  endtask

  initial begin
    int d0;
    for (int i = 0; i < N; i++) begin m_sh[i] = '0; m_act[i] = '0; end
    // reset, then scan from a dark display
    run(2);
    Resetn = 1'b1; enable = 1'b1;
    run(70);

    // shadow writes without commit leave the display at 0
    for (int i = 0; i < N; i++) wr(i, i + 1);
    run(20);
    commit = 1'b1; step();
    d0 = done_cnt;
    run(80);
    chk("commit_single_done", done_cnt - d0, 1);

    // three commits in one frame, plus a write on the frame_tick cycle
    wait_show(0);
    d0 = done_cnt;
    commit = 1'b1; step(); run(3);
    commit = 1'b1; step(); run(3);
    commit = 1'b1; step();
    wait_tick();
    wr(2, 9);
    run(40);
    chk("triple_commit_done", done_cnt - d0, 1);

    // out-of-range write index is ignored
    wr(5, 15);
    commit = 1'b1; step();
    run(70);

    // enable drops while a commit is pending
    wr(1, 7);
    wait_show(0);
    commit = 1'b1; step();
    wait_show(2);
    enable = 1'b0; step();
    chk("off_anodes", digit_an, 4'hF);
    chk("off_busy_held", commit_busy, 1);
    step();
    chk("off_copy_done", commit_done, 1);
    run(3);
    enable = 1'b1;
    run(40);

    // reset in the middle of a pending commit
    wr(3, 6);
    wait_show(0);
    commit = 1'b1; step();
    wait_show(1);
    d0 = done_cnt;
    Resetn = 1'b0; step();
    chk("rst_anodes", digit_an, 4'hF);
    chk("rst_busy", commit_busy, 0);
    Resetn = 1'b1;
    commit = 1'b1; step();
    run(70);
    chk("rst_no_stale_done", done_cnt - d0, 1);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      Resetn   = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_digit = 3'($urandom_range(0, 7));
      wr_data  = 4'($urandom);
      commit   = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
